// File: rtl/stopwatch_lap_viewer.sv
// rtl/stopwatch_lap_viewer.sv - read-side browser for stored stopwatch lap records
//
// Lets the user step through lap records held in the lap memory. Steps can be
// manual (next/prev with wrap-around) or automatic, paced by an external tick.
// The memory read data is captured into field registers for the display mux.
//
// Ports:
//   iClk      - system clock
//   iRst      - synchronous active-high reset
//   iLapCnt   - number of stored laps; values above DEPTH are treated as DEPTH
//   iEnter    - pulse: enter browse mode at the most recent lap
//   iExit     - pulse: leave browse mode
//   iNext     - pulse: step to the next lap
//   iPrev     - pulse: step to the previous lap
//   iAutoTgl  - pulse: toggle between manual browsing and auto-scroll
//   iTick     - pacing pulse for auto-scroll
//   oAddr     - memory read address (the index register)
//   iRData    - asynchronous memory read data {hour, min, sec, centi}
//   oActive   - browsing or auto-scrolling
//   oAuto     - auto-scrolling
//   oIdx      - 1-based displayed lap number, 0 when idle
//   oValid    - field outputs belong to the current oAddr
//   oHour/oMin/oSec/oCenti - registered record fields

module stopwatch_lap_viewer #(
    parameter int DEPTH      = 30,
    parameter int AUTO_TICKS = 100
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic [5:0]  iLapCnt,
    input  logic        iEnter,
    input  logic        iExit,
    input  logic        iNext,
    input  logic        iPrev,
    input  logic        iAutoTgl,
    input  logic        iTick,
    output logic [4:0]  oAddr,
    input  logic [27:0] iRData,
    output logic        oActive,
    output logic        oAuto,
    output logic [4:0]  oIdx,
    output logic        oValid,
    output logic [6:0]  oHour,
    output logic [6:0]  oMin,
    output logic [6:0]  oSec,
    output logic [6:0]  oCenti
);

    localparam int             TW        = (AUTO_TICKS > 1) ? $clog2(AUTO_TICKS) : 1;
    localparam logic [5:0]     DEPTH_W   = 6'(DEPTH);
    localparam logic [TW-1:0]  TICK_LAST = TW'(AUTO_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BROWSE = 2'd1,
        S_AUTO   = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [4:0]      index, index_n;
    logic [TW-1:0]   tick_cnt, tick_cnt_n;

    logic [5:0]      lap_cnt_eff;
    logic [4:0]      last_idx;
    logic [4:0]      idx_inc;
    logic [4:0]      idx_dec;
    logic            step_next;
    logic            step_prev;

    logic            active_q;
    logic            auto_q;
    logic [4:0]      disp_idx_q;
    logic            valid_q;
    logic [27:0]     fields_q;

    assign lap_cnt_eff = (iLapCnt > DEPTH_W) ? DEPTH_W : iLapCnt;
    // Only meaningful while lap_cnt_eff > 0; the C=0 case is handled before any use.
    assign last_idx    = 5'(lap_cnt_eff - 6'd1);
    assign idx_inc     = (index == last_idx) ? 5'd0 : index + 5'd1;
    assign idx_dec     = (index == 5'd0) ? last_idx : index - 5'd1;

    // Simultaneous next and prev cancel each other out.
    assign step_next   = iNext & ~iPrev;
    assign step_prev   = iPrev & ~iNext;

    always_comb begin
        state_n    = state;
        index_n    = index;
        tick_cnt_n = tick_cnt;
        case (state)
            S_IDLE: begin
                if (iEnter && (lap_cnt_eff != 6'd0)) begin
                    state_n = S_BROWSE;
                    index_n = last_idx;
                end
            end
            default: begin
                if ((lap_cnt_eff == 6'd0) || iExit) begin
                    state_n    = S_IDLE;
                    index_n    = 5'd0;
                    tick_cnt_n = '0;
                end else if ({1'b0, index} >= lap_cnt_eff) begin
                    // The memory shrank underneath us; this cycle is spent clamping.
                    index_n = last_idx;
                end else if (iAutoTgl) begin
                    state_n    = (state == S_AUTO) ? S_BROWSE : S_AUTO;
                    tick_cnt_n = '0;
                end else if (step_next) begin
                    index_n    = idx_inc;
                    tick_cnt_n = '0;
                end else if (step_prev) begin
                    index_n    = idx_dec;
                    tick_cnt_n = '0;
                end else if ((state == S_AUTO) && iTick) begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt_n = '0;
                        index_n    = idx_inc;
                    end else begin
                        tick_cnt_n = tick_cnt + TW'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state      <= S_IDLE;
            index      <= 5'd0;
            tick_cnt   <= '0;
            active_q   <= 1'b0;
            auto_q     <= 1'b0;
            disp_idx_q <= 5'd0;
            valid_q    <= 1'b0;
            fields_q   <= 28'd0;
        end else begin
            state      <= state_n;
            index      <= index_n;
            tick_cnt   <= tick_cnt_n;
            active_q   <= (state_n != S_IDLE);
            auto_q     <= (state_n == S_AUTO);
            disp_idx_q <= (state_n != S_IDLE) ? index_n + 5'd1 : 5'd0;
            // Fields loaded on this edge reflect the address held before it, so
            // they only describe the new address if the index did not move.
            valid_q    <= (state_n != S_IDLE) && (state != S_IDLE) && (index_n == index);
            if (state_n == S_IDLE) begin
                fields_q <= 28'd0;
            end else if (state != S_IDLE) begin
                fields_q <= iRData;
            end
        end
    end

    assign oAddr   = index;
    assign oActive = active_q;
    assign oAuto   = auto_q;
    assign oIdx    = disp_idx_q;
    assign oValid  = valid_q;
    assign oHour   = fields_q[27:21];
    assign oMin    = fields_q[20:14];
    assign oSec    = fields_q[13:7];
    assign oCenti  = fields_q[6:0];

endmodule
